// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: write-back selector, FSM states, flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        REG  = 2'b01,
        MEM  = 2'b10,
        RSVD = 2'b11
    } wb_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_t;

    // Bit positions inside the architectural flag register {za,zb,eq,gt,lt}.
    localparam int FLAG_ZA = 4;
    localparam int FLAG_ZB = 3;
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;
    localparam int FLAG_W  = 5;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/wb_stage_if.sv
// Execute-to-writeback result bus: one ALU result per valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: the writeback side drives in_ready; the execute side holds its result while it is low.
interface wb_stage_if;
    import wb_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_in;
    logic [15:0] addr_in;
    wb_sel_t     wb_sel;
    logic        flag_en;
    logic        za_in;
    logic        zb_in;
    logic        eq_in;
    logic        gt_in;
    logic        lt_in;

    // Execute stage side.
    modport master (
        output in_valid, alu_in, addr_in, wb_sel, flag_en,
        output za_in, zb_in, eq_in, gt_in, lt_in,
        input  in_ready
    );

    // Writeback stage side.
    modport slave (
        input  in_valid, alu_in, addr_in, wb_sel, flag_en,
        input  za_in, zb_in, eq_in, gt_in, lt_in,
        output in_ready
    );

endinterface

// File: rtl/wb_mem_ctrl.sv
// Store engine: holds one 16-bit store on mem_req until mem_ack or timeout.
// Latency: mem_req rises 1 cycle after start; done/timeout are same-cycle combinational pulses.
// Backpressure: busy is high for the whole MEM_WAIT period so the parent can stall upstream.
module wb_mem_ctrl
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] start_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        done,
    output logic        timeout
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    wb_state_t  state_q;
    wb_state_t  state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_inc;

    // State, wait counter and the latched store address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_req <= (state_d == MEM_WAIT);
            if (start) begin
                mem_addr  <= start_addr;
                mem_wdata <= start_data;
            end
        end
    end

    // Next state: ack beats a coinciding timeout; the counter counts unacked request cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        timeout = 1'b0;
        cnt_inc = cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == MEM_WAIT);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results to the register file, the flag register or data memory.
// Latency: register write and flag update 1 cycle after accept; stores occupy 2..MEM_TIMEOUT+1 cycles.
// Backpressure: in_ready is low during reset and while a store is outstanding.
module wb_stage
    import wb_pkg::*;
#(
    parameter int REG_AW      = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    wb_stage_if.slave         up,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [15:0]       rf_wdata,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output flags_t            flags_q,
    output logic [15:0]       retired,
    output logic              err
);

    logic   accept;
    logic   mem_busy;
    logic   mem_done;
    logic   mem_timeout;
    logic   retire;
    logic   set_err;
    flags_t flags_in;

    assign up.in_ready = !mem_busy && !rst;
    assign accept      = up.in_valid && up.in_ready;

    // Pack the compare flags into their architectural bit positions.
    always_comb begin
        flags_in          = '0;
        flags_in[FLAG_ZA] = up.za_in;
        flags_in[FLAG_ZB] = up.zb_in;
        flags_in[FLAG_EQ] = up.eq_in;
        flags_in[FLAG_GT] = up.gt_in;
        flags_in[FLAG_LT] = up.lt_in;
    end

    assign retire  = (accept && (up.wb_sel == NONE || up.wb_sel == REG)) || mem_done;
    assign set_err = (accept && up.wb_sel == RSVD) || mem_timeout;

    wb_mem_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (accept && up.wb_sel == MEM),
        .start_addr (up.addr_in),
        .start_data (up.alu_in),
        .mem_ack    (mem_ack),
        .busy       (mem_busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .done       (mem_done),
        .timeout    (mem_timeout)
    );

    // Register-file write port, flag register, retire counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flags_q  <= '0;
            retired  <= '0;
            err      <= 1'b0;
        end else begin
            rf_we <= accept && (up.wb_sel == REG);
            if (accept && up.wb_sel == REG) begin
                rf_waddr <= up.addr_in[REG_AW-1:0];
                rf_wdata <= up.alu_in;
            end
            if (accept && up.flag_en) begin
                flags_q <= flags_in;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: transaction-level model plus directed literal checks.
// Latency: n/a.
// Backpressure: the model tracks store occupancy on its own and predicts in_ready from it.
module tb_wb_stage;
    import wb_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ack;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    flags_t      flags_q;
    logic [15:0] retired;
    logic        err;

    wb_stage_if up_if ();

    wb_stage #(
        .REG_AW      (3),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up        (up_if),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .flags_q   (flags_q),
        .retired   (retired),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a store is "outstanding" for some number of cycles; everything
    // else is a one-cycle retire or write event.
    bit  m_busy     = 1'b0;
    int  m_waited   = 0;
    int  m_retired  = 0;
    bit  m_err      = 1'b0;
    int  m_flags    = 0;
    bit  m_rf_we    = 1'b0;
    int  m_rf_addr  = 0;
    int  m_rf_data  = 0;
    int  m_mem_addr = 0;
    int  m_mem_data = 0;

    always @(posedge clk) begin
        m_rf_we = 1'b0;
        if (rst) begin
            m_busy = 0; m_waited = 0; m_retired = 0; m_err = 0; m_flags = 0;
            m_rf_addr = 0; m_rf_data = 0; m_mem_addr = 0; m_mem_data = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy    = 1'b0;
                m_retired = (m_retired + 1) % 65536;
            end else begin
                m_waited++;
                if (m_waited >= TO) begin
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end
            end
        end else if (up_if.in_valid) begin
            if (up_if.flag_en)
                m_flags = 16 * int'(up_if.za_in) + 8 * int'(up_if.zb_in) + 4 * int'(up_if.eq_in)
                        + 2 * int'(up_if.gt_in) + int'(up_if.lt_in);
            case (up_if.wb_sel)
                NONE: m_retired = (m_retired + 1) % 65536;
                REG: begin
                    m_rf_we   = 1'b1;
                    m_rf_addr = int'(up_if.addr_in) % 8;
                    m_rf_data = int'(up_if.alu_in);
                    m_retired = (m_retired + 1) % 65536;
                end
                MEM: begin
                    m_busy     = 1'b1;
                    m_waited   = 0;
                    m_mem_addr = int'(up_if.addr_in);
                    m_mem_data = int'(up_if.alu_in);
                end
                default: m_err = 1'b1;
            endcase
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(up_if.in_ready), 32'(!m_busy && !rst));
            chk("rf_we",     32'(rf_we),          32'(m_rf_we));
            chk("rf_waddr",  32'(rf_waddr),       32'(m_rf_addr));
            chk("rf_wdata",  32'(rf_wdata),       32'(m_rf_data));
            chk("mem_req",   32'(mem_req),        32'(m_busy));
            chk("mem_addr",  32'(mem_addr),       32'(m_mem_addr));
            chk("mem_wdata", 32'(mem_wdata),      32'(m_mem_data));
            chk("flags_q",   32'(flags_q),        32'(m_flags));
            chk("retired",   32'(retired),        32'(m_retired));
            chk("err",       32'(err),            32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic za, input logic zb, input logic eq, input logic gt, input logic lt);
        up_if.za_in = za; up_if.zb_in = zb; up_if.eq_in = eq; up_if.gt_in = gt; up_if.lt_in = lt;
    endtask

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        up_if.in_valid = 1'b0;
        up_if.alu_in = '0;
        up_if.addr_in = '0;
        up_if.wb_sel = NONE;
        up_if.flag_en = 1'b0;
        set_flags(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(up_if.in_ready), 32'd0);
        chk("reset retired",  32'(retired), 32'd0);
        chk("reset mem_req",  32'(mem_req), 32'd0);
        chk("reset err",      32'(err), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("in_ready after reset", 32'(up_if.in_ready), 32'd1);

        // Three back-to-back register writes.
        for (int i = 0; i < 3; i++) begin
            up_if.in_valid = 1'b1;
            up_if.wb_sel   = REG;
            up_if.addr_in  = 16'(i + 1);
            up_if.alu_in   = 16'(32'h1111 * (i + 1));
            tick();
            chk("reg rf_we",    32'(rf_we), 32'd1);
            chk("reg rf_waddr", 32'(rf_waddr), 32'(i + 1));
            chk("reg rf_wdata", 32'(rf_wdata), 32'h1111 * 32'(i + 1));
        end
        up_if.in_valid = 1'b0;
        chk("reg retired", 32'(retired), 32'd3);
        tick();
        chk("rf_we pulse ends", 32'(rf_we), 32'd0);

        // Store acked on the 4th request cycle (also the timeout cycle: ack must win).
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = MEM;
        up_if.addr_in  = 16'h0040;
        up_if.alu_in   = 16'hBEEF;
        tick();
        up_if.in_valid = 1'b0;
        chk("store mem_addr",  32'(mem_addr), 32'h0040);
        chk("store mem_wdata", 32'(mem_wdata), 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            chk("store mem_req held", 32'(mem_req), 32'd1);
            chk("store stall",        32'(up_if.in_ready), 32'd0);
            tick();
        end
        chk("store mem_req 4th", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("store mem_req drop", 32'(mem_req), 32'd0);
        chk("store in_ready",     32'(up_if.in_ready), 32'd1);
        chk("store retired",      32'(retired), 32'd4);
        chk("store err",          32'(err), 32'd0);

        // Flag latch with NONE, then held when flag_en is low.
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = NONE;
        up_if.flag_en  = 1'b1;
        set_flags(0, 0, 1, 0, 0);
        tick();
        chk("flags latched", 32'(flags_q), 32'b00100);
        up_if.flag_en = 1'b0;
        set_flags(1, 0, 0, 1, 1);
        tick();
        up_if.in_valid = 1'b0;
        set_flags(0, 0, 0, 0, 0);
        chk("flags held",    32'(flags_q), 32'b00100);
        chk("flags retired", 32'(retired), 32'd6);

        // Store that is never acked.
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = MEM;
        up_if.addr_in  = 16'h0080;
        up_if.alu_in   = 16'h1234;
        tick();
        up_if.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("timeout mem_req held", 32'(mem_req), 32'd1);
            tick();
        end
        chk("timeout mem_req 4th", 32'(mem_req), 32'd1);
        tick();
        chk("timeout mem_req drop", 32'(mem_req), 32'd0);
        chk("timeout err",          32'(err), 32'd1);
        chk("timeout retired",      32'(retired), 32'd6);
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = REG;
        up_if.addr_in  = 16'h000D;
        up_if.alu_in   = 16'hA5A5;
        tick();
        up_if.in_valid = 1'b0;
        chk("post-timeout rf_waddr", 32'(rf_waddr), 32'd5);
        chk("post-timeout rf_wdata", 32'(rf_wdata), 32'hA5A5);
        chk("post-timeout retired",  32'(retired), 32'd7);

        // Reset clears the sticky error; ack with no request is ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst err",     32'(err), 32'd0);
        chk("rst retired", 32'(retired), 32'd0);
        chk("rst flags",   32'(flags_q), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray ack mem_req", 32'(mem_req), 32'd0);
        chk("stray ack retired", 32'(retired), 32'd0);

        // Reserved selector.
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = RSVD;
        tick();
        up_if.in_valid = 1'b0;
        chk("rsvd rf_we",   32'(rf_we), 32'd0);
        chk("rsvd mem_req", 32'(mem_req), 32'd0);
        chk("rsvd err",     32'(err), 32'd1);
        chk("rsvd retired", 32'(retired), 32'd0);

        // Retire counter wrap.
        chk_en = 1'b0;
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = NONE;
        repeat (65535) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("retired max", 32'(retired), 32'hFFFF);
        tick();
        up_if.in_valid = 1'b0;
        chk("retired wrap", 32'(retired), 32'h0000);

        // Reset in the middle of a store.
        up_if.in_valid = 1'b1;
        up_if.wb_sel   = MEM;
        up_if.addr_in  = 16'h0100;
        up_if.alu_in   = 16'h5555;
        tick();
        up_if.in_valid = 1'b0;
        chk("midstore mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst mem_req",   32'(mem_req), 32'd0);
        chk("midrst mem_addr",  32'(mem_addr), 32'd0);
        chk("midrst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("midrst err",       32'(err), 32'd0);
        chk("midrst in_ready",  32'(up_if.in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst retired",       32'(retired), 32'd0);
        chk("midrst in_ready after", 32'(up_if.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
